// File: rtl/bus_cmd_sequencer_pkg.sv
// Shared types and constants for the ISA bus command sequencer.
package bus_cmd_sequencer_pkg;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CTRL_W     = 8;
  localparam int unsigned CTRL_READ  = 0;
  localparam int unsigned CTRL_WRITE = 1;
  localparam int unsigned CMD_W      = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  // One queued host command as stored in the FIFO.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // Bus-cycle request byte for a given direction; exactly one bit set.
  function automatic logic [CTRL_W-1:0] ctrl_req(input logic write);
    logic [CTRL_W-1:0] v;
    v = '0;
    if (write) v[CTRL_WRITE] = 1'b1;
    else       v[CTRL_READ]  = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_cmd_sequencer_if.sv
// Host command, bus-cycle and response signals of the sequencer.
interface bus_cmd_sequencer_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  import bus_cmd_sequencer_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [CTRL_W-1:0] control_out;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              data_read_n;
  logic              control_reset_n;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              timeout_err;
  logic [CNT_W-1:0]  fifo_count;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data,
    input  bus_rdata, data_read_n, control_reset_n, rsp_ready,
    output cmd_ready, control_out, bus_addr, bus_wdata,
    output rsp_valid, rsp_data, rsp_err, busy, timeout_err, fifo_count
  );

  // Host / bus state machine side.
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_data,
    output bus_rdata, data_read_n, control_reset_n, rsp_ready,
    input  cmd_ready, control_out, bus_addr, bus_wdata,
    input  rsp_valid, rsp_data, rsp_err, busy, timeout_err, fifo_count
  );

endinterface

// File: rtl/bus_cmd_sequencer_cmd_fifo.sv
// Synchronous command FIFO; head is visible combinationally from storage,
// so a word pushed this cycle cannot be popped until the next one.
module cmd_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push && (r_count < CNT_W'(DEPTH));
  assign w_pop_ok  = i_pop && (r_count != '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);

  // Storage write; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_cmd_sequencer.sv
// Queues host I/O commands and drives them one at a time to the ISA bus
// state machine, with acknowledge timeout and read-response handshake.
module bus_cmd_sequencer
  import bus_cmd_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                clk,
  input  logic                reset,
  bus_cmd_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t            r_state;
  logic [CTRL_W-1:0] r_ctrl;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_write;
  logic [DATA_W-1:0] r_rdata;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_busy;
  logic              r_timeout_err;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_ready;
  logic [CNT_W-1:0]  w_count;
  logic [CMD_W-1:0]  w_head_bits;
  cmd_t              w_head;
  cmd_t              w_in;
  logic              w_ack;
  logic              w_dstrobe;
  logic              w_tmo_hit;

  assign w_ready   = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_push    = bus.cmd_valid && w_ready;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty && !r_rsp_valid;
  assign w_in      = '{write: bus.cmd_write, addr: bus.cmd_addr, data: bus.cmd_data};
  assign w_head    = cmd_t'(w_head_bits);
  assign w_ack     = !bus.control_reset_n;
  assign w_dstrobe = !bus.data_read_n;
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (CMD_W'(w_in)),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // Command sequencing FSM with registered bus request and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ctrl        <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_write       <= 1'b0;
      r_rdata       <= '0;
      r_tmo_cnt     <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_addr  <= w_head.addr;
            r_wdata <= w_head.data;
            r_write <= w_head.write;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_ctrl    <= ctrl_req(r_write);
          r_tmo_cnt <= '0;
          r_rdata   <= '0;
          r_state   <= ST_WAIT_ACK;
        end

        ST_WAIT_ACK: begin
          if (w_dstrobe) r_rdata <= bus.bus_rdata;
          // Acknowledge takes priority over a coincident timeout.
          if (w_ack) begin
            r_ctrl <= '0;
            if (r_write) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_dstrobe ? bus.bus_rdata : r_rdata;
              r_rsp_err   <= 1'b0;
              r_state     <= ST_RESP;
            end
          end else if (w_tmo_hit) begin
            r_ctrl        <= '0;
            r_timeout_err <= 1'b1;
            if (r_write) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= 8'hFF;
              r_rsp_err   <= 1'b1;
              r_state     <= ST_RESP;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = w_ready;
  assign bus.fifo_count  = w_count;
  assign bus.control_out = r_ctrl;
  assign bus.bus_addr    = r_addr;
  assign bus.bus_wdata   = r_wdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_bus_cmd_sequencer.sv
// Self-checking bench: transaction-level model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_bus_cmd_sequencer;
  import bus_cmd_sequencer_pkg::*;

  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic cmp_en   = 1'b0;

  bus_cmd_sequencer_if #(.FIFO_DEPTH(FIFO_DEPTH)) ifc ();

  bus_cmd_sequencer #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Model: queue of pending commands plus one in-flight command with its age.
  cmd_t       mq[$];
  cmd_t       m_cur;
  bit         m_infl;
  int         m_age;
  logic [7:0] m_ctrl, m_cap, m_rsp_data, m_wdata;
  logic [9:0] m_addr;
  bit         m_rsp_valid, m_rsp_err, m_terr;

  task automatic m_finish(input bit timed_out);
    m_ctrl = 8'h00;
    if (timed_out) m_terr = 1'b1;
    if (m_cur.write) m_infl = 1'b0;
    else begin
      m_rsp_valid = 1'b1;
      m_rsp_data  = timed_out ? 8'hFF : m_cap;
      m_rsp_err   = timed_out;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    int   n_before;
    bit   do_push;
    cmd_t incoming;
    if (reset) begin
      mq.delete();
      m_infl = 0; m_age = 0; m_ctrl = 0; m_cap = 0; m_addr = 0; m_wdata = 0;
      m_rsp_valid = 0; m_rsp_data = 0; m_rsp_err = 0; m_terr = 0;
      m_cur = '0;
    end else begin
      n_before = mq.size();
      do_push  = ifc.cmd_valid && (n_before < FIFO_DEPTH);
      incoming = '{write: ifc.cmd_write, addr: ifc.cmd_addr, data: ifc.cmd_data};
      if (m_rsp_valid) begin
        if (ifc.rsp_ready) begin
          m_rsp_valid = 0;
          m_infl      = 0;
        end
      end else if (m_infl) begin
        if (m_age == 0) begin
          m_ctrl = m_cur.write ? 8'h02 : 8'h01;
          m_age  = 1;
        end else begin
          if (!ifc.data_read_n) m_cap = ifc.bus_rdata;
          if (!ifc.control_reset_n)        m_finish(1'b0);
          else if (m_age == TIMEOUT_CYCLES) m_finish(1'b1);
          else                              m_age++;
        end
      end else if (n_before > 0) begin
        m_cur   = mq.pop_front();
        m_infl  = 1;
        m_age   = 0;
        m_cap   = 8'h00;
        m_addr  = m_cur.addr;
        m_wdata = m_cur.data;
      end
      if (do_push) mq.push_back(incoming);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("cyc_control_out", 32'(ifc.control_out), 32'(m_ctrl));
      chk("cyc_bus_addr",    32'(ifc.bus_addr),    32'(m_addr));
      chk("cyc_bus_wdata",   32'(ifc.bus_wdata),   32'(m_wdata));
      chk("cyc_rsp_valid",   32'(ifc.rsp_valid),   32'(m_rsp_valid));
      chk("cyc_rsp_data",    32'(ifc.rsp_data),    32'(m_rsp_data));
      chk("cyc_rsp_err",     32'(ifc.rsp_err),     32'(m_rsp_err));
      chk("cyc_busy",        32'(ifc.busy),        32'(m_infl));
      chk("cyc_timeout_err", 32'(ifc.timeout_err), 32'(m_terr));
      chk("cyc_fifo_count",  32'(ifc.fifo_count),  32'(mq.size()));
      chk("cyc_cmd_ready",   32'(ifc.cmd_ready),   32'(mq.size() < FIFO_DEPTH));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_control_out", 32'(ifc.control_out), 32'h00);
    chk("rst_bus_addr",    32'(ifc.bus_addr),    32'h0);
    chk("rst_bus_wdata",   32'(ifc.bus_wdata),   32'h0);
    chk("rst_rsp_valid",   32'(ifc.rsp_valid),   32'h0);
    chk("rst_rsp_data",    32'(ifc.rsp_data),    32'h0);
    chk("rst_busy",        32'(ifc.busy),        32'h0);
    chk("rst_timeout_err", 32'(ifc.timeout_err), 32'h0);
    chk("rst_fifo_count",  32'(ifc.fifo_count),  32'h0);
    chk("rst_cmd_ready",   32'(ifc.cmd_ready),   32'h1);
    reset = 1'b0;
    tick();
  endtask

  task automatic push(input logic w, input logic [9:0] a, input logic [7:0] d);
    int n;
    n = 0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = w;
    ifc.cmd_addr  = a;
    ifc.cmd_data  = d;
    while (!ifc.cmd_ready && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) bound_fail("push_ready");
    tick();
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_ctrl(input logic [7:0] exp);
    int n;
    n = 0;
    while (ifc.control_out !== exp && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) bound_fail("wait_control_out");
  endtask

  task automatic ack(input logic strobe, input logic [7:0] rd);
    ifc.control_reset_n = 1'b0;
    ifc.data_read_n     = !strobe;
    ifc.bus_rdata       = rd;
    tick();
    ifc.control_reset_n = 1'b1;
    ifc.data_read_n     = 1'b1;
    ifc.bus_rdata       = 8'h00;
  endtask

  task automatic take_rsp();
    ifc.rsp_ready = 1'b1;
    tick();
    ifc.rsp_ready = 1'b0;
    chk("rsp_dropped", 32'(ifc.rsp_valid), 32'h0);
  endtask

  initial begin
    int n;
    ifc.cmd_valid = 0; ifc.cmd_write = 0; ifc.cmd_addr = '0; ifc.cmd_data = '0;
    ifc.bus_rdata = '0; ifc.data_read_n = 1; ifc.control_reset_n = 1; ifc.rsp_ready = 0;
    do_reset();
    cmp_en = 1'b1;

    // Write with acknowledge four cycles after the request appears.
    push(1'b1, 10'h220, 8'h5A);
    wait_ctrl(8'h02);
    chk("wr_bus_addr",  32'(ifc.bus_addr),  32'h220);
    chk("wr_bus_wdata", 32'(ifc.bus_wdata), 32'h5A);
    chk("wr_busy",      32'(ifc.busy),      32'h1);
    repeat (3) tick();
    ack(1'b0, 8'h00);
    chk("wr_ctrl_cleared", 32'(ifc.control_out), 32'h00);
    chk("wr_busy_low",     32'(ifc.busy),        32'h0);

    // Read with data strobe then acknowledge; response held until accepted.
    push(1'b0, 10'h388, 8'h00);
    wait_ctrl(8'h01);
    chk("rd_bus_addr", 32'(ifc.bus_addr), 32'h388);
    ifc.data_read_n = 1'b0;
    ifc.bus_rdata   = 8'h3C;
    tick();
    ifc.data_read_n = 1'b1;
    ifc.bus_rdata   = 8'h00;
    ack(1'b0, 8'h00);
    chk("rd_ctrl_cleared", 32'(ifc.control_out), 32'h00);
    chk("rd_rsp_valid",    32'(ifc.rsp_valid),   32'h1);
    chk("rd_rsp_data",     32'(ifc.rsp_data),    32'h3C);
    chk("rd_rsp_err",      32'(ifc.rsp_err),     32'h0);
    repeat (3) tick();
    chk("rd_rsp_held",      32'(ifc.rsp_valid), 32'h1);
    chk("rd_rsp_data_held", 32'(ifc.rsp_data),  32'h3C);
    take_rsp();

    // Five writes with no acknowledge fill the FIFO; then drain in order.
    for (int i = 0; i < 5; i++) push(1'b1, 10'(10'h100 + i), 8'(8'h10 + i));
    chk("full_cmd_ready",  32'(ifc.cmd_ready),  32'h0);
    chk("full_fifo_count", 32'(ifc.fifo_count), 32'h4);
    for (int i = 0; i < 5; i++) begin
      wait_ctrl(8'h02);
      chk("order_addr",  32'(ifc.bus_addr),  32'h100 + 32'(i));
      chk("order_wdata", 32'(ifc.bus_wdata), 32'h10 + 32'(i));
      ack(1'b0, 8'h00);
    end
    tick();
    chk("drain_fifo_count", 32'(ifc.fifo_count), 32'h0);

    // Read with no acknowledge times out after 32 waiting cycles.
    push(1'b0, 10'h1F0, 8'h00);
    wait_ctrl(8'h01);
    n = 0;
    while (ifc.control_out != 8'h00 && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_cycles",      32'(n),               32'd32);
    chk("tmo_rsp_valid",   32'(ifc.rsp_valid),   32'h1);
    chk("tmo_rsp_data",    32'(ifc.rsp_data),    32'hFF);
    chk("tmo_rsp_err",     32'(ifc.rsp_err),     32'h1);
    chk("tmo_timeout_err", 32'(ifc.timeout_err), 32'h1);
    take_rsp();
    chk("tmo_sticky", 32'(ifc.timeout_err), 32'h1);

    // Acknowledge on the very edge that would time out: normal completion.
    do_reset();
    push(1'b0, 10'h2F0, 8'h00);
    wait_ctrl(8'h01);
    repeat (31) tick();
    chk("race_ctrl_still_set", 32'(ifc.control_out), 32'h01);
    ack(1'b1, 8'hA5);
    chk("race_ctrl_cleared", 32'(ifc.control_out), 32'h00);
    chk("race_rsp_valid",    32'(ifc.rsp_valid),   32'h1);
    chk("race_rsp_data",     32'(ifc.rsp_data),    32'hA5);
    chk("race_rsp_err",      32'(ifc.rsp_err),     32'h0);
    chk("race_timeout_err",  32'(ifc.timeout_err), 32'h0);
    take_rsp();

    // Reset mid-cycle while waiting with two commands queued.
    for (int i = 0; i < 3; i++) push(1'b1, 10'(10'h300 + i), 8'(8'hC0 + i));
    wait_ctrl(8'h02);
    chk("mid_fifo_count", 32'(ifc.fifo_count), 32'h2);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_control_out", 32'(ifc.control_out), 32'h00);
    chk("arst_fifo_count",  32'(ifc.fifo_count),  32'h0);
    chk("arst_busy",        32'(ifc.busy),        32'h0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_busy",       32'(ifc.busy),        32'h0);
    chk("post_rst_ctrl",       32'(ifc.control_out), 32'h00);
    chk("post_rst_fifo_count", 32'(ifc.fifo_count),  32'h0);

    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end

endmodule
